// File: rtl/rf_pkg.sv
// Shared constants for the pipeline register file: operand-select modes
// and the power-on register image.
package rf_pkg;

    localparam logic [1:0] RF_MODE_A   = 2'b00;
    localparam logic [1:0] RF_MODE_LS  = 2'b01;
    localparam logic [1:0] RF_MODE_DIV = 2'b10;
    localparam logic [1:0] RF_MODE_BR  = 2'b11;

    localparam int RF_INIT_N = 16;

    localparam logic [15:0] RF_INIT_IMG [RF_INIT_N] = '{
        16'h0000, 16'h0F00, 16'h0050, 16'hFF0F,
        16'hF0FF, 16'h0040, 16'h0024, 16'h00FF,
        16'hAAAA, 16'h0000, 16'h0000, 16'h0000,
        16'hFFFF, 16'h0002, 16'h0000, 16'h0000
    };

    function automatic logic [15:0] rf_init_val(input logic [3:0] idx);
        return RF_INIT_IMG[idx];
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking and RAW-hazard stall for the register file.
// Writes clear, accepted issues set; set beats clear on the same register.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter bit BYPASS_EN = 1'b1,
    localparam int NUM_REGS = 2**ADDR_W
) (
    input  logic                CLOCK,
    input  logic                in_rst_n,
    input  logic                in_rd_valid,
    input  logic [1:0]          in_rd_mode,
    input  logic [ADDR_W-1:0]   in_src1_addr,
    input  logic [ADDR_W-1:0]   in_src2_addr,
    input  logic                in_set_en,
    input  logic [ADDR_W-1:0]   in_set_addr,
    input  logic [NUM_REGS-1:0] in_clr,
    output logic [NUM_REGS-1:0] out_busy,
    output logic                out_stall
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] set_vec;
    logic [ADDR_W-1:0]   src2;
    logic                haz1;
    logic                haz2;

    // Branch mode compares against R0 instead of the second source.
    assign src2 = (in_rd_mode == RF_MODE_BR) ? '0 : in_src2_addr;

    assign haz1 = busy_q[in_src1_addr] & ~(BYPASS_EN & in_clr[in_src1_addr]);
    assign haz2 = busy_q[src2] & ~(BYPASS_EN & in_clr[src2]);

    assign out_stall = in_rd_valid & (haz1 | haz2);

    always_comb begin
        set_vec = '0;
        if (in_set_en && !out_stall) begin
            set_vec[in_set_addr] = 1'b1;
        end
    end

    assign busy_d = (busy_q & ~in_clr) | set_vec;

    always_ff @(posedge CLOCK or negedge in_rst_n) begin
        if (!in_rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign out_busy = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two registered read ports, writeback and R0 write
// ports, optional write-to-read bypass and a busy scoreboard.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 4,
    parameter bit BYPASS_EN = 1'b1,
    localparam int NUM_REGS = 2**ADDR_W
) (
    input  logic                CLOCK,
    input  logic                in_rst_n,
    input  logic                in_rd_valid,
    input  logic [1:0]          in_rd_mode,
    input  logic [ADDR_W-1:0]   in_op1_addr,
    input  logic [ADDR_W-1:0]   in_op2_addr,
    input  logic                in_issue_en,
    input  logic [ADDR_W-1:0]   in_issue_addr,
    input  logic                in_wr_en,
    input  logic [ADDR_W-1:0]   in_wr_addr,
    input  logic [DATA_W-1:0]   in_wr_data,
    input  logic                in_r0_wr_en,
    input  logic [DATA_W-1:0]   in_r0_data,
    output logic [DATA_W-1:0]   out_op1_data,
    output logic [DATA_W-1:0]   out_op2_data,
    output logic                out_rd_valid,
    output logic                out_stall,
    output logic [NUM_REGS-1:0] out_busy
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   op1_q;
    logic [DATA_W-1:0]   op1_d;
    logic [DATA_W-1:0]   op2_q;
    logic [DATA_W-1:0]   op2_d;
    logic                vld_q;
    logic [NUM_REGS-1:0] wr_hit;
    logic                fire;

    always_comb begin
        wr_hit = '0;
        if (in_wr_en) begin
            wr_hit[in_wr_addr] = 1'b1;
        end
        if (in_r0_wr_en) begin
            wr_hit[0] = 1'b1;
        end
    end

    rf_scoreboard #(
        .ADDR_W    (ADDR_W),
        .BYPASS_EN (BYPASS_EN)
    ) u_sb (
        .CLOCK        (CLOCK),
        .in_rst_n     (in_rst_n),
        .in_rd_valid  (in_rd_valid),
        .in_rd_mode   (in_rd_mode),
        .in_src1_addr (in_op1_addr),
        .in_src2_addr (in_op2_addr),
        .in_set_en    (in_issue_en),
        .in_set_addr  (in_issue_addr),
        .in_clr       (wr_hit),
        .out_busy     (out_busy),
        .out_stall    (out_stall)
    );

    assign fire = in_rd_valid & ~out_stall;

    // R0 port has priority over the writeback port, in bypass as in the array.
    function automatic logic [DATA_W-1:0] src_val(input logic [ADDR_W-1:0] a);
        if (BYPASS_EN && in_r0_wr_en && a == '0) begin
            return in_r0_data;
        end
        if (BYPASS_EN && in_wr_en && in_wr_addr == a) begin
            return in_wr_data;
        end
        return regs_q[a];
    endfunction

    always_comb begin
        op1_d = op1_q;
        op2_d = op2_q;
        if (fire) begin
            case (in_rd_mode)
                RF_MODE_LS: begin
                    op1_d = src_val(in_op2_addr);
                    op2_d = src_val(in_op1_addr);
                end
                RF_MODE_BR: begin
                    op1_d = src_val(in_op1_addr);
                    op2_d = src_val('0);
                end
                default: begin
                    op1_d = src_val(in_op1_addr);
                    op2_d = src_val(in_op2_addr);
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge in_rst_n) begin
        if (!in_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (DATA_W == 16 && i < RF_INIT_N) begin
                    regs_q[i] <= DATA_W'(rf_init_val(i[3:0]));
                end else begin
                    regs_q[i] <= '0;
                end
            end
        end else begin
            if (in_wr_en) begin
                regs_q[in_wr_addr] <= in_wr_data;
            end
            if (in_r0_wr_en) begin
                regs_q[0] <= in_r0_data;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge in_rst_n) begin
        if (!in_rst_n) begin
            op1_q <= '0;
            op2_q <= '0;
            vld_q <= 1'b0;
        end else begin
            op1_q <= op1_d;
            op2_q <= op2_d;
            vld_q <= fire;
        end
    end

    assign out_op1_data = op1_q;
    assign out_op2_data = op2_q;
    assign out_rd_valid = vld_q;

endmodule
